// File: rtl/fpcvt_pkg.sv
// Shared types and width helpers for the serial fixed-to-float converter.
// Latency: n/a. Backpressure: n/a.
package fpcvt_pkg;

    localparam int FPCVT_E_W = 3;
    localparam int FPCVT_F_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_emax(input int e_w);
        return (1 << e_w) - 1;
    endfunction

    function automatic int calc_dw(input int e_w, input int f_w);
        return f_w + (1 << e_w);
    endfunction

    // Field widths follow the package widths; the top defaults to these.
    typedef struct packed {
        logic                 s;
        logic [FPCVT_E_W-1:0] e;
        logic [FPCVT_F_W-1:0] f;
        logic                 sat;
    } res_t;

endpackage

// File: rtl/fpcvt_if.sv
// Sample-in / float-out handshake bundle for fpcvt_seq.
// Latency: n/a. Backpressure: valid/ready on both sides.
interface fpcvt_if #(
    parameter int E_W = 3,
    parameter int F_W = 4
);
    localparam int D_W = fpcvt_pkg::calc_dw(E_W, F_W);

    logic           in_valid;
    logic           in_ready;
    logic [D_W-1:0] d;
    logic           out_valid;
    logic           out_ready;
    logic           s;
    logic [E_W-1:0] e;
    logic [F_W-1:0] f;
    logic           sat;

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, s, e, f, sat
    );

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, s, e, f, sat
    );

endinterface

// File: rtl/fpcvt_round.sv
// Rounds the normalised magnitude to F_W bits and saturates on exponent overflow.
// Latency: combinational. Backpressure: none. Rounding enabled by FPCVT_ROUND_EN.
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int E_W = FPCVT_E_W,
    parameter int F_W = FPCVT_F_W
) (
    input  logic [F_W:0]   mag_hi_i,
    input  logic [E_W-1:0] exp_i,
    input  logic           sat_i,
    output logic [F_W-1:0] frac_o,
    output logic [E_W-1:0] exp_o,
    output logic           sat_o
);

    localparam int EMAX = calc_emax(E_W);

`ifdef FPCVT_ROUND_EN
    logic [F_W:0] sum;

    always_comb begin
        sum    = {1'b0, mag_hi_i[F_W:1]} + {{F_W{1'b0}}, mag_hi_i[0]};
        frac_o = sum[F_W-1:0];
        exp_o  = exp_i;
        sat_o  = sat_i;
        if (sum[F_W]) begin
            if (exp_i == E_W'(EMAX)) begin
                exp_o  = E_W'(EMAX);
                frac_o = '1;
                sat_o  = 1'b1;
            end else begin
                exp_o  = exp_i + 1'b1;
                frac_o = {1'b1, {(F_W-1){1'b0}}};
            end
        end
    end
`else
    logic unused_rbit;

    assign unused_rbit = mag_hi_i[0];

    always_comb begin
        frac_o = mag_hi_i[F_W:1];
        exp_o  = exp_i;
        sat_o  = sat_i;
    end
`endif

endmodule

// File: rtl/fpcvt_seq.sv
// Serial fixed-to-float converter: one normalising left shift per clock, then a round step.
// Latency: k+2 cycles from accept (k = shifts, 0..EMAX). Backpressure: holds result while out_ready=0, in_ready=0 until handshake.
// FPCVT_ROUND_EN selects round-half-up; undefined gives truncation.
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter int E_W = FPCVT_E_W,
    parameter int F_W = FPCVT_F_W
) (
    input  logic   clk,
    input  logic   rst_n,
    fpcvt_if.slave io
);

    localparam int D_W  = calc_dw(E_W, F_W);
    localparam int M_W  = D_W - 1;
    localparam int EMAX = calc_emax(E_W);

    state_t         state_q, state_d;
    logic [M_W-1:0] mag_q, mag_d;
    logic [E_W-1:0] exp_q, exp_d;
    logic           sign_q, sign_d;
    logic           satp_q, satp_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    res_t           res_q, res_d;

    logic [D_W-1:0] d_neg;
    logic           d_is_min;
    logic [F_W-1:0] rnd_frac;
    logic [E_W-1:0] rnd_exp;
    logic           rnd_sat;

    fpcvt_round #(
        .E_W (E_W),
        .F_W (F_W)
    ) u_round (
        .mag_hi_i (mag_q[M_W-1 -: F_W+1]),
        .exp_i    (exp_q),
        .sat_i    (satp_q),
        .frac_o   (rnd_frac),
        .exp_o    (rnd_exp),
        .sat_o    (rnd_sat)
    );

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        satp_d      = satp_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        d_neg       = -io.d;
        d_is_min    = (io.d == {1'b1, {(D_W-1){1'b0}}});

        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    sign_d     = io.d[D_W-1];
                    mag_d      = io.d[D_W-1] ? d_neg[M_W-1:0] : io.d[M_W-1:0];
                    // -2^(D_W-1) has no M_W-bit magnitude; clamp and flag it.
                    if (d_is_min) begin
                        mag_d = '1;
                    end
                    satp_d     = d_is_min;
                    exp_d      = E_W'(EMAX);
                    in_ready_d = 1'b0;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (mag_q[M_W-1] || (exp_q == '0)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[M_W-2:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end
            end
            ROUND: begin
                res_d.s     = sign_q;
                res_d.e     = rnd_exp;
                res_d.f     = rnd_frac;
                res_d.sat   = rnd_sat;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            satp_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            satp_q      <= satp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.s         = res_q.s;
    assign io.e         = res_q.e;
    assign io.f         = res_q.f;
    assign io.sat       = res_q.sat;

endmodule

// File: tb/tb_fpcvt_seq.sv
// Directed bench for fpcvt_seq at default widths; expectations follow FPCVT_ROUND_EN.
module tb_fpcvt_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fpcvt_if #(.E_W(3), .F_W(4)) io ();

    fpcvt_seq #(.E_W(3), .F_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packing {s, e[2:0], f[3:0], sat}
    localparam int NV = 9;
    logic [11:0] vec_d   [NV] = '{12'd20, 12'd50, 12'd69, 12'd420, 12'd31,
                                  12'd2047, 12'h800, 12'd0, 12'hFCE};
    int          vec_lat [NV] = '{8, 7, 6, 4, 8, 2, 2, 9, 7};
`ifdef FPCVT_ROUND_EN
    logic [8:0]  vec_res [NV] = '{{1'b0, 3'd1, 4'b1010, 1'b0},
                                  {1'b0, 3'd2, 4'b1101, 1'b0},
                                  {1'b0, 3'd3, 4'b1001, 1'b0},
                                  {1'b0, 3'd5, 4'b1101, 1'b0},
                                  {1'b0, 3'd2, 4'b1000, 1'b0},
                                  {1'b0, 3'd7, 4'b1111, 1'b1},
                                  {1'b1, 3'd7, 4'b1111, 1'b1},
                                  {1'b0, 3'd0, 4'b0000, 1'b0},
                                  {1'b1, 3'd2, 4'b1101, 1'b0}};
`else
    logic [8:0]  vec_res [NV] = '{{1'b0, 3'd1, 4'b1010, 1'b0},
                                  {1'b0, 3'd2, 4'b1100, 1'b0},
                                  {1'b0, 3'd3, 4'b1000, 1'b0},
                                  {1'b0, 3'd5, 4'b1101, 1'b0},
                                  {1'b0, 3'd1, 4'b1111, 1'b0},
                                  {1'b0, 3'd7, 4'b1111, 1'b0},
                                  {1'b1, 3'd7, 4'b1111, 1'b1},
                                  {1'b0, 3'd0, 4'b0000, 1'b0},
                                  {1'b1, 3'd2, 4'b1100, 1'b0}};
`endif

    task automatic convert(input logic [11:0] din, output int lat, output logic [8:0] res);
        int n;
        n = 0;
        while (!io.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        io.d        = din;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        lat = 0;
        while (!io.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {io.s, io.e, io.f, io.sat};
        if (io.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({io.in_ready, io.out_valid, io.s, io.e, io.f, io.sat} !== {1'b1, 1'b0, 9'd0}) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=000",
                     io.in_ready, io.out_valid, {io.s, io.e, io.f, io.sat});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({io.in_ready, io.out_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_idle: got rdy=%b vld=%b, want rdy=1 vld=0", io.in_ready, io.out_valid);
        end
    endtask

    task automatic test_vectors();
        int         lat;
        logic [8:0] res;
        for (int i = 0; i < NV; i++) begin
            convert(vec_d[i], lat, res);
            n_checks++;
            if (res !== vec_res[i]) begin
                n_errors++;
                $display("FAIL vec_result d=%h: got s/e/f/sat=%b, want %b", vec_d[i], res, vec_res[i]);
            end
            n_checks++;
            if (lat !== vec_lat[i]) begin
                n_errors++;
                $display("FAIL vec_latency d=%h: got %0d, want %0d", vec_d[i], lat, vec_lat[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int         lat;
        logic [8:0] res;
        io.out_ready = 1'b0;
        convert(12'd69, lat, res);
        n_checks++;
        if (res !== vec_res[2]) begin
            n_errors++;
            $display("FAIL bp_result: got %b, want %b", res, vec_res[2]);
        end
        io.in_valid = 1'b1;
        io.d        = 12'd20;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({io.s, io.e, io.f, io.sat, io.out_valid, io.in_ready} !== {vec_res[2], 2'b10}) begin
                n_errors++;
                $display("FAIL bp_hold cyc=%0d: got res=%b vld=%b rdy=%b, want res=%b vld=1 rdy=0",
                         c, {io.s, io.e, io.f, io.sat}, io.out_valid, io.in_ready, vec_res[2]);
            end
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({io.out_valid, io.in_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", io.out_valid, io.in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (io.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_no_accept: got vld=%b, want 0", io.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [8:0] res;
        io.d        = 12'd20;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({io.in_ready, io.out_valid, io.s, io.e, io.f, io.sat} !== {1'b1, 1'b0, 9'd0}) begin
            n_errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%b, want rdy=1 vld=0 res=0",
                     io.in_ready, io.out_valid, {io.s, io.e, io.f, io.sat});
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        convert(12'd69, lat, res);
        n_checks++;
        if (res !== vec_res[2] || lat !== 6) begin
            n_errors++;
            $display("FAIL reset_mid_next: got res=%b lat=%0d, want res=%b lat=6", res, lat, vec_res[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] bb_d   [4] = '{12'd20, 12'd50, 12'd69, 12'd420};
        logic        acc;
        int          nacc;
        int          nres;
        nacc = 0;
        nres = 0;
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.d         = bb_d[0];
        for (int cyc = 0; cyc < 200 && nres < 4; cyc++) begin
            acc = io.in_valid && io.in_ready;
            if (io.out_valid) begin
                n_checks++;
                if ({io.s, io.e, io.f, io.sat} !== vec_res[nres]) begin
                    n_errors++;
                    $display("FAIL b2b_result idx=%0d: got %b, want %b", nres,
                             {io.s, io.e, io.f, io.sat}, vec_res[nres]);
                end
                nres++;
            end
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 4) io.d = bb_d[nacc];
                else io.in_valid = 1'b0;
            end
        end
        io.in_valid = 1'b0;
        n_checks++;
        if (nres !== 4 || nacc !== 4) begin
            n_errors++;
            $display("FAIL b2b_count: got results=%0d accepts=%0d, want 4 and 4", nres, nacc);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.d         = '0;
        io.out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpcvt_seq.md
Name: fpcvt_seq

Overview:
- Parametrised, handshaked successor to the combinational 12-bit fixed-to-float converter.
- Converts a D_W-bit two's-complement sample into sign / E_W-bit exponent / F_W-bit fraction. Encoded value = (-1)^s × f × 2^e.
- Normalisation is serial: one left shift per clock, so area stays flat as widths grow.
- Sits between the sample source and downstream float consumers, with valid/ready on both sides.

Parameters:
- E_W, 3, exponent width; maximum exponent EMAX = 2^E_W - 1.
- F_W, 4, fraction width.
- D_W is a derived localparam, not user-set: D_W = F_W + 2^E_W (12 at defaults). Magnitude width is M_W = D_W - 1.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, d is valid.
- in_ready, out, 1, block can accept a sample.
- d, in, D_W, two's-complement input.
- out_valid, out, 1, s/e/f/sat are valid.
- out_ready, in, 1, consumer accepts the result.
- s, out, 1, sign.
- e, out, E_W, exponent.
- f, out, F_W, fraction.
- sat, out, 1, result was clamped to maximum magnitude.

Behaviour:
- Interface (decided): single clock clk; rst_n is asynchronous, active-low.
- Reset: state IDLE; in_ready=1; out_valid=0; s, e, f and sat = 0; internal registers cleared. Reset asserted mid-conversion aborts the sample and drops it silently.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE (in_ready=1). On in_valid at an edge:
  - capture s = d[D_W-1];
  - mag = |d| in M_W bits; if d = -2^(D_W-1), force mag to all-ones and set sat_pending;
  - set exp = EMAX; go to NORM.
- NORM (in_ready=0):
  - if mag[M_W-1]=1 or exp=0, go to ROUND;
  - otherwise shift mag left by 1 (zero fill), decrement exp, stay in NORM.
- ROUND:
  - frac = mag[M_W-1 -: F_W]; rbit = mag[M_W-1-F_W].
  - If rbit=1, frac = frac+1.
  - If the increment carries out: frac = 1 followed by zeros (1000 at F_W=4) and exp = exp+1.
  - If exp would exceed EMAX: exp = EMAX, frac = all-ones, set sat.
  - Register the results to s/e/f/sat; go to DONE.
- DONE: out_valid=1. Outputs stay stable while out_ready=0. On out_ready, out_valid drops next cycle and the FSM returns to IDLE. No input is accepted in the same cycle as the output handshake.
- Latency: out_valid rises k+2 edges after the accepting edge, where k = number of shifts (0..EMAX). At defaults: 2 to 9 cycles. Throughput is one sample per (latency+1) cycles minimum.
- Zero input: k = EMAX, giving e=0, f=0, s=0.
- Negative values use the same magnitude path; s=1. Negative zero cannot occur.
- Rounding is round-half-up on magnitude, i.e. symmetric about zero.

Optional Feature:
- Macro: FPCVT_ROUND_EN.
- Defined: ROUND applies rbit as described above.
- Undefined: truncation. rbit is ignored, sat is set only for the most-negative input, and ROUND still takes one cycle so latency is unchanged.

Decomposition:
- Shared package fpcvt_pkg holds:
  - the state enum (IDLE/NORM/ROUND/DONE);
  - helper functions for EMAX and D_W derived from E_W and F_W;
  - a result struct {s, e, f, sat}.
- One natural sub-module: fpcvt_round. It is combinational and takes mag/exp to frac/exp/sat, so the rounding and saturation rules are unit-testable on their own.

Test Plan (defaults, ROUND_EN defined):
- d=20 -> s0 e1 f1010 sat0, out_valid 8 cycles after accept. d=50 -> e2 f1101 (52). d=69 -> e3 f1001 (72). d=420 -> e5 f1101 (416).
- d=31 -> rounding carry: e2 f1000 (32). d=2047 -> e7 f1111 sat1. d=-2048 -> s1 e7 f1111 sat1. d=0 -> s0 e0 f0, latency 9.
- d=-50 -> s1 e2 f1101. Repeat d=50 with ROUND_EN undefined -> f1100 (48), sat0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> s/e/f constant, in_ready=0, in_valid ignored. Then out_ready=1 -> out_valid drops next cycle and in_ready=1.
- Reset: pulse rst_n low during NORM of d=20 -> all outputs 0 immediately, FSM in IDLE. Next sample d=69 converts correctly.
- Back-to-back: in_valid held high with a stream of 20, 50, 69, 420 and out_ready=1 -> four results in order, with no sample lost or duplicated.
